// File: rtl/nibble_packer_pkg.sv
// Shared definitions for the nibble packer: nibble width, default word depth
// and the FSM state encoding.
package nibble_packer_pkg;

  localparam int unsigned NIB_W        = 4;
  localparam int unsigned NNIB_DEFAULT = 8;
  localparam int unsigned CNT_W        = 4;

  typedef enum logic {
    FILL = 1'b0,
    PEND = 1'b1
  } state_e;

endpackage

// File: rtl/nibble_packer.sv
// Packs a stream of nibbles LSB-first into NNIB-nibble words, with an early
// close on IN_LAST, a fill accumulator and a one-entry output register.
module nibble_packer #(
  parameter int unsigned NNIB  = nibble_packer_pkg::NNIB_DEFAULT,
  parameter int unsigned NIB_W = nibble_packer_pkg::NIB_W
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NIB_W-1:0]      IN_DATA,
  input  logic                  IN_VALID,
  input  logic                  IN_LAST,
  output logic                  IN_READY,
  output logic [NNIB*NIB_W-1:0] OUT_DATA,
  output logic [3:0]            OUT_COUNT,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY
);
  import nibble_packer_pkg::*;

  localparam int unsigned W = NNIB * NIB_W;

  state_e           state_q, state_d;
  logic [W-1:0]     acc_data_q, acc_data_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_valid_q, out_valid_d;

  logic [W-1:0]     fill_data;
  logic [CNT_W-1:0] fill_cnt;
  logic             word_done;
  logic             out_free;
  logic             out_drain;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= FILL;
      acc_data_q  <= '0;
      acc_cnt_q   <= '0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_data_q  <= acc_data_d;
      acc_cnt_q   <= acc_cnt_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_data_d  = acc_data_q;
    acc_cnt_d   = acc_cnt_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    out_drain   = out_valid_q & OUT_READY;
    out_free    = ~out_valid_q | OUT_READY;
    // A drained word clears valid unless a new word is loaded below.
    out_valid_d = out_valid_q & ~OUT_READY;

    fill_data = acc_data_q;
    for (int unsigned k = 0; k < NNIB; k++) begin
      if (acc_cnt_q == CNT_W'(k)) begin
        fill_data[k*NIB_W +: NIB_W] = IN_DATA;
      end
    end
    fill_cnt  = acc_cnt_q + CNT_W'(1);
    word_done = IN_LAST | (acc_cnt_q == CNT_W'(NNIB - 1));

    case (state_q)
      FILL: begin
        if (IN_VALID) begin
          if (word_done && out_free) begin
            out_data_d  = fill_data;
            out_cnt_d   = fill_cnt;
            out_valid_d = 1'b1;
            acc_data_d  = '0;
            acc_cnt_d   = '0;
          end else begin
            acc_data_d = fill_data;
            acc_cnt_d  = fill_cnt;
            if (word_done) begin
              state_d = PEND;
            end
          end
        end
      end
      PEND: begin
        if (out_drain) begin
          out_data_d  = acc_data_q;
          out_cnt_d   = acc_cnt_q;
          out_valid_d = 1'b1;
          acc_data_d  = '0;
          acc_cnt_d   = '0;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign IN_READY  = (state_q == FILL);
  assign OUT_DATA  = out_data_q;
  assign OUT_COUNT = out_cnt_q;
  assign OUT_VALID = out_valid_q;

endmodule
